hs_source: RTL and testbench

Valid/ready transmitter that drives the upstream side of the team's 4-bit valid/ready bus and pipeline slices. On a start command it emits a burst of len_i words, incrementing from seed_i, with a programmable idle gap between words. It obeys backpressure from ready_i and reports completion. It is the initiator used in front of handshake pipeline stages, both in silicon test traffic and in bench stimulus.

---
 rtl/hs_source.sv | 119 +++++++++++
 tb/tb_hs_source.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hs_source.sv
// Valid/ready burst transmitter: emits len_i incrementing words from seed_i with a gap between words.
// Optional backpressure counter is built when HS_SRC_STALL_CNT_EN is defined.
module hs_source #(
  parameter int DW   = 4,
  parameter int LENW = 8,
  parameter int GAPW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_i,
  input  logic [LENW-1:0] len_i,
  input  logic [DW-1:0]   seed_i,
  input  logic [GAPW-1:0] gap_i,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  input  logic            ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [LENW-1:0] sent_o,
  output logic [15:0]     stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t          state;
  logic [LENW-1:0] len_q;
  logic [GAPW-1:0] gap_q;
  logic [GAPW-1:0] gap_cnt;
  logic [LENW-1:0] sent_next;

  assign sent_next = sent_o + 1'b1;

  // Every output is a flop so nothing downstream sees a path from ready_i.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sent_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            len_q  <= len_i;
            gap_q  <= gap_i;
            sent_o <= '0;
            busy_o <= 1'b1;
            if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state   <= SEND;
              valid_o <= 1'b1;
              data_o  <= seed_i;
            end
          end
        end
        SEND: begin
          if (ready_i) begin
            sent_o <= sent_next;
            if (sent_next == len_q) begin
              state   <= DONE;
              valid_o <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              data_o <= data_o + 1'b1;
              if (gap_q != '0) begin
                state   <= GAP;
                valid_o <= 1'b0;
                gap_cnt <= gap_q;
              end
            end
          end
        end
        // gap_cnt starts at the gap length, so the last idle cycle is at count 1.
        GAP: begin
          if (gap_cnt == GAPW'(1)) begin
            state   <= SEND;
            valid_o <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HS_SRC_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts cycles the current word is offered but refused; sticks at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (state == IDLE && start_i) begin
      stall_q <= '0;
    end else if (state == SEND && !ready_i && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_hs_source.sv
// Self-checking bench for hs_source: directed table, hand sequences (ignored start, mid-burst reset)
// and randomized bursts checked against a word-by-word timeline model.
module tb_hs_source;
  localparam int DW   = 4;
  localparam int LENW = 8;
  localparam int GAPW = 4;
  localparam int MAXC = 512;

  logic            clk;
  logic            rstn;
  logic            start_i;
  logic [LENW-1:0] len_i;
  logic [DW-1:0]   seed_i;
  logic [GAPW-1:0] gap_i;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic            ready_i;
  logic            busy_o;
  logic            done_o;
  logic [LENW-1:0] sent_o;
  logic [15:0]     stall_cnt_o;

  hs_source #(.DW(DW), .LENW(LENW), .GAPW(GAPW)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .seed_i(seed_i),
    .gap_i(gap_i), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o), .sent_o(sent_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HS_SRC_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    int len; int seed; int gap; int hold;
    int exp_done; int exp_sent; int exp_stall; int exp_last;
  } vec_t;

  vec_t vecs[5];
  int   n_cmp;
  int   n_fail;

  bit rdy[MAXC];
  bit e_valid[MAXC];
  int e_data[MAXC];
  int e_sent[MAXC];
  int e_stall[MAXC];
  int e_done;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setReadyHold(input int hold);
    for (int c = 0; c < MAXC; c++) rdy[c] = (c >= hold);
  endtask

  task automatic setReadyRandom(input int pct);
    for (int c = 0; c < MAXC; c++)
      rdy[c] = (c >= MAXC / 2) || ($urandom_range(99) < pct);
  endtask

  // Timeline of the burst: each word is offered until the first ready cycle,
  // followed by gap idle cycles unless it was the final word.
  task automatic buildModel(input int len, input int seed, input int gap);
    int c, s, st;
    for (int i = 0; i < MAXC; i++) begin
      e_valid[i] = 1'b0; e_data[i] = 0; e_sent[i] = 0; e_stall[i] = 0;
    end
    c = 0; s = 0; st = 0;
    for (int k = 0; k < len; k++) begin
      while (!rdy[c]) begin
        e_valid[c] = 1'b1; e_data[c] = (seed + k) % 16; e_sent[c] = s; e_stall[c] = st;
        if (st < 65535) st++;
        c++;
      end
      e_valid[c] = 1'b1; e_data[c] = (seed + k) % 16; e_sent[c] = s; e_stall[c] = st;
      s++; c++;
      if (k < len - 1)
        for (int g = 0; g < gap; g++) begin
          e_sent[c] = s; e_stall[c] = st; c++;
        end
    end
    e_done = c;
    e_sent[c] = s; e_stall[c] = st;
    e_sent[c+1] = s; e_stall[c+1] = st;
  endtask

  // Runs one burst from a start edge through the idle cycle after done_o,
  // checking every cycle against the model and returning a few observations.
  task automatic applyStimulus(input int len, input int seed, input int gap, input bit poke,
                               output int last_data, output int done_seen,
                               output int sent_seen, output int stall_seen);
    buildModel(len, seed, gap);
    @(negedge clk);
    start_i = 1'b1; len_i = LENW'(len); seed_i = DW'(seed); gap_i = GAPW'(gap);
    @(posedge clk); #1;
    start_i = 1'b0;
    len_i = LENW'($urandom); seed_i = DW'($urandom); gap_i = GAPW'($urandom);
    last_data = -1; done_seen = -1; sent_seen = -1; stall_seen = -1;
    for (int c = 0; c <= e_done + 1; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      ready_i = rdy[c];
      if (poke && c == 1) start_i = 1'b1;
      if (poke && c == 3) start_i = 1'b0;
      checkOutput("valid", valid_o, e_valid[c]);
      if (e_valid[c]) checkOutput("data", data_o, e_data[c]);
      checkOutput("busy", busy_o, (c <= e_done));
      checkOutput("done", done_o, (c == e_done));
      checkOutput("sent", sent_o, e_sent[c]);
      checkOutput("stall", stall_cnt_o, STALL_EN ? e_stall[c] : 0);
      if (done_o) done_seen = c;
      if (valid_o && ready_i) last_data = int'(data_o);
      if (c == e_done) begin
        sent_seen = int'(sent_o);
        stall_seen = int'(stall_cnt_o);
      end
    end
    start_i = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input bit poke);
    int last_data, done_seen, sent_seen, stall_seen;
    setReadyHold(v.hold);
    applyStimulus(v.len, v.seed, v.gap, poke, last_data, done_seen, sent_seen, stall_seen);
    checkOutput("vec_done_cycle", done_seen, v.exp_done);
    checkOutput("vec_sent", sent_seen, v.exp_sent);
    checkOutput("vec_stall", stall_seen, STALL_EN ? v.exp_stall : 0);
    checkOutput("vec_last_data", last_data, v.exp_last);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, valid_o, 0);
    checkOutput({tag, "_data"}, data_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_sent"}, sent_o, 0);
    checkOutput({tag, "_stall"}, stall_cnt_o, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int last_data, done_seen, sent_seen, stall_seen;
    int len, seed, gap;
    n_cmp = 0; n_fail = 0;
    vecs[0] = '{len: 4, seed: 3,  gap: 0, hold: 0, exp_done: 4, exp_sent: 4, exp_stall: 0, exp_last: 6};
    vecs[1] = '{len: 2, seed: 9,  gap: 0, hold: 3, exp_done: 5, exp_sent: 2, exp_stall: 3, exp_last: 10};
    vecs[2] = '{len: 3, seed: 0,  gap: 2, hold: 0, exp_done: 7, exp_sent: 3, exp_stall: 0, exp_last: 2};
    vecs[3] = '{len: 4, seed: 14, gap: 0, hold: 0, exp_done: 4, exp_sent: 4, exp_stall: 0, exp_last: 1};
    vecs[4] = '{len: 0, seed: 7,  gap: 1, hold: 0, exp_done: 0, exp_sent: 0, exp_stall: 0, exp_last: -1};

    rstn = 1'b0; start_i = 1'b0; len_i = '0; seed_i = '0; gap_i = '0; ready_i = 1'b1;
    #23;
    checkAllZero("reset");
    @(negedge clk); rstn = 1'b1;

    $display("[TB] directed table");
    for (int i = 0; i < 5; i++) runVector(vecs[i], 1'b0);

    $display("[TB] start pulsed mid-burst");
    runVector(vecs[2], 1'b1);

    $display("[TB] reset mid-burst");
    setReadyHold(0);
    @(negedge clk);
    start_i = 1'b1; len_i = 8'd8; seed_i = 4'd5; gap_i = 4'd0; ready_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checkAllZero("midrst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_done", done_o, 0);
    end
    @(negedge clk); rstn = 1'b1;
    runVector(vecs[0], 1'b0);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(12);
      seed = $urandom_range(15);
      gap = $urandom_range(3);
      setReadyRandom($urandom_range(30, 100));
      applyStimulus(len, seed, gap, (len >= 2) && $urandom_range(1) == 1,
                    last_data, done_seen, sent_seen, stall_seen);
      checkOutput("rnd_done_cycle", done_seen, e_done);
      checkOutput("rnd_last_data", last_data, (len == 0) ? -1 : (seed + len - 1) % 16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
